// File: rtl/pingpong_pkg.sv
// Shared types and constants for the pingpong counter seeker.
package pingpong_pkg;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned STEP_W = 5;

   localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;
   // Counter values at which the counter ignores a flip request
   localparam logic [CNT_W-1:0] FLIP_LO = 4'd1;
   localparam logic [CNT_W-1:0] FLIP_HI = 4'd14;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StSeek,
      StDone
   } state_e;

   // True where the counter would drop a flip request
   function automatic logic no_flip_pos(input logic [CNT_W-1:0] v);
      return (v == FLIP_LO) || (v == FLIP_HI);
   endfunction

endpackage

// File: rtl/pingpong_seek_stats.sv
// Per-request statistics: step count and flip count captured on entry to DONE.
// Only instantiated when PINGPONG_SEEK_STATS_EN is defined.
module pingpong_seek_stats
   import pingpong_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              flip,
   input  logic              load,
   input  logic [STEP_W-1:0] steps,
   output logic [STEP_W-1:0] last_steps,
   output logic [3:0]        last_flips
);

   logic [3:0] flip_cnt_q;

   // Running flip count for the active request, saturating at 15
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flip_cnt_q <= '0;
      end else if (clear) begin
         flip_cnt_q <= '0;
      end else if (flip && (flip_cnt_q != 4'hf)) begin
         flip_cnt_q <= flip_cnt_q + 4'd1;
      end
   end

   // Snapshot on the edge entering DONE; held until the next completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_steps <= '0;
         last_flips <= '0;
      end else if (load) begin
         last_steps <= steps;
         last_flips <= flip_cnt_q;
      end
   end

endmodule

// File: rtl/pingpong_seeker.sv
// Closed-loop seeker: steps and reverses a pingpong counter until it reaches
// the requested target, then pulses done (err flags a watchdog expiry).
// Optional feature macro: PINGPONG_SEEK_STATS_EN adds last_steps/last_flips.
module pingpong_seeker
   import pingpong_pkg::*;
#(
   parameter int unsigned MAX_STEPS = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [CNT_W-1:0]  req_target,
   output logic              req_ready,
   input  logic              abort,
   input  logic [CNT_W-1:0]  cnt_out,
   input  logic              cnt_dir,
   output logic              hold,
   output logic              flip,
   output logic              busy,
   output logic              done,
`ifdef PINGPONG_SEEK_STATS_EN
   output logic [STEP_W-1:0] last_steps,
   output logic [3:0]        last_flips,
`endif
   output logic              err
);

   localparam logic [STEP_W-1:0] MaxSteps = STEP_W'(MAX_STEPS);

   state_e            state_q;
   logic [CNT_W-1:0]  target_q;
   logic [STEP_W-1:0] steps_q;
   logic              done_q;
   logic              err_q;

   logic match, behind, wd_hit, stepping;

   // Seek decisions; the counter only moves in cycles where stepping is set
   always_comb begin
      match    = (cnt_out == target_q);
      behind   = ((cnt_dir == DIR_UP) && (target_q < cnt_out)) ||
                 ((cnt_dir == DIR_DN) && (target_q > cnt_out));
      wd_hit   = (steps_q == MaxSteps);
      stepping = (state_q == StSeek) && !abort && !match && !wd_hit;
      hold     = !stepping;
      // At 1 or 14 a flip is dropped, so let the counter auto-reverse instead
      flip     = stepping && behind && !no_flip_pos(cnt_out);
   end

   assign req_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign err       = err_q;

   // Control FSM with registered done/err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         target_q <= '0;
         steps_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  target_q <= req_target;
                  steps_q  <= '0;
                  state_q  <= StSeek;
               end
            end
            StSeek: begin
               if (abort) begin
                  state_q <= StIdle;
               end else if (match) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  err_q   <= 1'b0;
               end else if (wd_hit) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else if (steps_q != '1) begin
                  steps_q <= steps_q + 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               err_q   <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef PINGPONG_SEEK_STATS_EN
   logic accept, enter_done;

   // Request acceptance and DONE entry strobes for the statistics block
   always_comb begin
      accept     = (state_q == StIdle) && req_valid;
      enter_done = (state_q == StSeek) && !abort && (match || wd_hit);
   end

   pingpong_seek_stats u_stats (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept),
      .flip       (flip),
      .load       (enter_done),
      .steps      (steps_q),
      .last_steps (last_steps),
      .last_flips (last_flips)
   );
`else
   // Statistics disabled: no counters, no extra ports
`endif

endmodule

// File: doc/pingpong_seeker.md
# pingpong_seeker

Closed-loop controller that steers a pingpong counter to a requested value. It drives the counter's `hold`/`flip` inputs and observes its `out`/`dir` outputs, so it acts as the initiator for the counter's control interface. A target is accepted through a valid/ready request, the counter is stepped and reversed until it reaches the target, and completion is reported with a one-cycle `done` pulse. Sits between the user/test control logic and the pingpong counter instance.

## Interface
- `MAX_STEPS`, default 31: watchdog limit on counter steps per request; range 1..31.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_target`  in  4  requested counter value, 0..15.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `abort`  in  1  cancels an active seek.
- `cnt_out`  in  4  counter value, from the counter's `out`.
- `cnt_dir`  in  1  counter direction, from the counter's `dir`; 0 = up, 1 = down.
- `hold`  out  1  to the counter; 1 freezes it.
- `flip`  out  1  to the counter; request a direction reversal.
- `busy`  out  1  high in SEEK and DONE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 means the watchdog expired.

## Operation
- Counter contract:
  - On each edge with `hold`=0, the counter steps +1 if dir=0 and −1 if dir=1, using the old dir.
  - The counter auto-reverses dir when stepping 14→15 or 1→0.
  - `flip` toggles dir at that edge, except when `cnt_out` is 1 or 14, where it is ignored by the counter.
- States: IDLE, SEEK, DONE.
  - IDLE: `hold`=1, `flip`=0. On accept, latch the target, clear the step count, go to SEEK.
  - SEEK, `cnt_out`==target: `hold`=1; next state DONE with err=0.
  - SEEK, no match: `hold`=0. Each such cycle increments the 5-bit step counter, which saturates at 31.
  - SEEK, step counter == MAX_STEPS without a match: `hold`=1; next state DONE with err=1.
  - DONE: `done`=1 for exactly one cycle, `hold`=1; next state IDLE.
- `hold` and `flip` are combinational from registered state, the latched target, `cnt_out` and `cnt_dir`.
- `flip`=1 only in SEEK with no match, target "behind", and `cnt_out` not in {1, 14}.
  - "Behind" means (dir=0 and target<cnt_out) or (dir=1 and target>cnt_out).
  - When flip is illegal, the controller lets the counter run to the end and auto-reverse.
- Abort:
  - `abort` in SEEK: IDLE next cycle, `hold`=1 combinationally in the abort cycle, no `done`.
  - `abort` in IDLE or DONE is ignored. Abort has priority over match and watchdog.
- Arithmetic: 4-bit unsigned compares, no wrap. The step counter is 5-bit saturating.

## Timing
- Reset values: state IDLE, `hold`=1, `flip`=0, `req_ready`=1, `busy`=0, `done`=0, `err`=0, step count 0.
- A reset asserted mid-seek forces IDLE immediately; no `done` is issued.
- For a request accepted at edge E0 that needs n steps:
  - SEEK spans E0..E(n+1).
  - `done` is high between E(n+1) and E(n+2).
  - n=0 gives `done` one cycle after acceptance.
- A flip costs one step in the old direction; the reversal is visible in `cnt_dir` on the next cycle.
- `req_ready` is low from E0 until the cycle after `done`. Back-to-back requests are therefore spaced at least n+3 cycles apart.

## Configuration
- `PINGPONG_SEEK_STATS_EN` defined:
  - Adds outputs `last_steps[4:0]` and `last_flips[3:0]`, both registered and reset to 0.
  - Both load on the edge entering DONE and hold until the next DONE.
  - `last_flips` counts the cycles where `flip`=1 and saturates at 15.
- `PINGPONG_SEEK_STATS_EN` undefined: these ports and the counters are absent; all other behaviour is identical.

## Structure
- Shared package `pingpong_pkg` contains:
  - the state enum (IDLE/SEEK/DONE);
  - `CNT_W`=4, `CNT_MAX`=15;
  - `FLIP_LO`=1, `FLIP_HI`=14 (no-flip values);
  - the `DIR_UP`=0 and `DIR_DN`=1 constants.
- One sub-module, `pingpong_seek_stats`, holds the statistics counters and is instantiated only under the macro.

## Test plan
- Reset:
  - Assert `rst` mid-seek → same cycle `hold`=1, `flip`=0, `req_ready`=1, `busy`=0, `done`=0.
- Forward seek:
  - Stimulus: counter at 3, dir=0, target 7.
  - Response: 4 steps, no `flip`, `done` at E5 with err=0, `hold`=1 once `cnt_out`=7 (stats: steps=4, flips=0).
- Reverse seek:
  - Stimulus: counter at 9, dir=0, target 5.
  - Response: `flip` high for one cycle at 9, sequence 9→10→9→8→7→6→5, `done` with steps=6, flips=1.
- Suppressed flip:
  - Stimulus: counter at 14, dir=0, target 12.
  - Response: `flip` stays 0, sequence 14→15→14→13→12, steps=4.
- Watchdog:
  - Stimulus: counter model frozen at 2, target 8, MAX_STEPS=31.
  - Response: `done` with err=1 exactly 32 cycles after acceptance.
- Abort and handshake:
  - Abort during SEEK → IDLE next cycle, no `done`.
  - A new request arriving while busy is not accepted until `req_ready` returns.
